// File: rtl/xm23_mem_pkg.sv
// +----------------------------------------------------------------------+
// | xm23_mem_pkg : shared types for the memory port arbiter              |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package xm23_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_RMW_WAIT = 2'd1,
    ARB_RMW_WR   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_LS   = 2'd2
  } rd_tag_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// +----------------------------------------------------------------------+
// | rd_tag_pipe : delay line carrying read ownership to the return cycle |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module rd_tag_pipe
  import xm23_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t push_tag,
  output rd_tag_t due_tag
);

  rd_tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= TAG_NONE;
    end else begin
      stages[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign due_tag = stages[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_port_arbiter : IF / LS sharing of one single-port word RAM       |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import xm23_mem_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_be,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              rmw_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int               SC_W       = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [1:0]       WAIT_LAST  = 2'(RD_LAT - 1);
  localparam int               HALF       = DATA_W / 2;

  arb_state_t          state, state_next;
  logic                reset_q;
  logic [SC_W-1:0]     starve_cnt;
  logic [1:0]          wait_cnt;
  logic [ADDR_W-1:0]   rmw_addr;
  logic [DATA_W-1:0]   rmw_wdata;
  logic                rmw_lo;
  logic                rmw_start;
  logic                hold_off;
  logic                ls_win;
  logic [DATA_W-1:0]   merged;
  rd_tag_t             push_tag, due_tag;

  // Grants are held off during reset and for one cycle after it.
  assign hold_off = reset | reset_q;
  assign ls_win   = ls_req & ~(if_req & (starve_cnt == STARVE_LIM));
  assign merged   = rmw_lo ? {mem_q[DATA_W-1:HALF], rmw_wdata[HALF-1:0]}
                           : {rmw_wdata[DATA_W-1:HALF], mem_q[HALF-1:0]};

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= state_next;
      if (!if_req || if_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
      if (rmw_start)
        wait_cnt <= '0;
      else if (state == ARB_RMW_WAIT)
        wait_cnt <= wait_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rmw_start) begin
      rmw_addr  <= ls_addr;
      rmw_wdata <= ls_wdata;
      rmw_lo    <= (ls_be == BE_LO);
    end
  end

  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    rmw_busy   = 1'b0;
    rmw_start  = 1'b0;
    mem_addr   = if_addr;
    mem_wdata  = ls_wdata;
    mem_wren   = 1'b0;
    push_tag   = TAG_NONE;
    case (state)
      ARB_IDLE: begin
        if (!hold_off) begin
          if (ls_win) begin
            ls_gnt   = 1'b1;
            mem_addr = ls_addr;
            if (!ls_we) begin
              push_tag = TAG_LS;
            end else begin
              case (ls_be)
                BE_WORD: mem_wren = 1'b1;
                BE_LO, BE_HI: begin
                  rmw_start  = 1'b1;
                  state_next = ARB_RMW_WAIT;
                end
                default: ;
              endcase
            end
          end else if (if_req) begin
            if_gnt   = 1'b1;
            push_tag = TAG_IF;
          end
        end
      end
      // Keep the RMW address on the bus so q still reflects it in RMW_WR.
      ARB_RMW_WAIT: begin
        rmw_busy = ~reset;
        mem_addr = rmw_addr;
        if (wait_cnt == WAIT_LAST) state_next = ARB_RMW_WR;
      end
      ARB_RMW_WR: begin
        rmw_busy   = ~reset;
        mem_addr   = rmw_addr;
        mem_wdata  = merged;
        mem_wren   = ~reset;
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_tag (push_tag),
    .due_tag  (due_tag)
  );

  assign if_rvalid = ~reset & (due_tag == TAG_IF);
  assign ls_rvalid = ~reset & (due_tag == TAG_LS);
  assign if_rdata  = mem_q;
  assign ls_rdata  = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : randomized bench with a transaction-level model |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_req, ls_we;
  logic [14:0] if_addr, ls_addr, mem_addr;
  logic [1:0]  ls_be;
  logic [15:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_q;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, rmw_busy, mem_wren;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(15), .DATA_W(16), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .rmw_busy(rmw_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  // Single-port synchronous RAM, read-before-write, one cycle latency.
  logic [15:0] ram [32768];
  logic        poke_en = 1'b0;
  logic [14:0] poke_addr;
  logic [15:0] poke_data;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  // Reference model state
  typedef struct { int due; bit is_ls; logic [15:0] data; } rd_t;
  rd_t         rq[$];
  logic [15:0] ref_mem [32768];
  int          starve, busy, cyc;
  bit          after_rst;
  logic [14:0] p_addr;
  logic [15:0] p_data;
  logic        m_ifg, m_lsg, s_lsg;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    logic e_ifg, e_lsg, e_busy, e_wren, e_ifv, e_lsv;
    logic [15:0] e_ifd, e_lsd;
    rd_t r;
    e_ifg = 0; e_lsg = 0; e_busy = 0; e_wren = 0; e_ifv = 0; e_lsv = 0;
    e_ifd = '0; e_lsd = '0;
    if (reset) begin
      rq.delete();
      busy = 0; starve = 0; after_rst = 1;
    end else begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.is_ls) begin e_lsv = 1; e_lsd = r.data; end
        else begin e_ifv = 1; e_ifd = r.data; end
      end
      if (busy > 0) begin
        e_busy = 1;
        if (busy == 1) begin
          e_wren = 1;
          check("rmw_addr", 32'(mem_addr), 32'(p_addr));
          check("rmw_wdata", 32'(mem_wdata), 32'(p_data));
          ref_mem[p_addr] = p_data;
        end
        busy--;
      end else if (!after_rst) begin
        if (ls_req && !(if_req && starve == STARVE_MAX)) begin
          e_lsg = 1;
          check("ls_mem_addr", 32'(mem_addr), 32'(ls_addr));
          if (!ls_we) begin
            rq.push_back('{cyc + RD_LAT, 1'b1, ref_mem[ls_addr]});
          end else if (ls_be == 2'b11) begin
            e_wren = 1;
            check("st_wdata", 32'(mem_wdata), 32'(ls_wdata));
            ref_mem[ls_addr] = ls_wdata;
          end else if (ls_be != 2'b00) begin
            busy   = RD_LAT + 1;
            p_addr = ls_addr;
            p_data = (ls_be == 2'b01) ? {ref_mem[ls_addr][15:8], ls_wdata[7:0]}
                                      : {ls_wdata[15:8], ref_mem[ls_addr][7:0]};
          end
        end else if (if_req) begin
          e_ifg = 1;
          check("if_mem_addr", 32'(mem_addr), 32'(if_addr));
          rq.push_back('{cyc + RD_LAT, 1'b0, ref_mem[if_addr]});
        end else begin
          check("idle_mem_addr", 32'(mem_addr), 32'(if_addr));
        end
      end
      after_rst = 0;
      if (if_req && !e_ifg) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
      else starve = 0;
    end
    check("if_gnt", 32'(if_gnt), 32'(e_ifg));
    check("ls_gnt", 32'(ls_gnt), 32'(e_lsg));
    check("rmw_busy", 32'(rmw_busy), 32'(e_busy));
    check("mem_wren", 32'(mem_wren), 32'(e_wren));
    check("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
    check("ls_rvalid", 32'(ls_rvalid), 32'(e_lsv));
    if (e_ifv) check("if_rdata", 32'(if_rdata), 32'(e_ifd));
    if (e_lsv) check("ls_rdata", 32'(ls_rdata), 32'(e_lsd));
    m_ifg = e_ifg; m_lsg = e_lsg; s_lsg = ls_gnt;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [14:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic ls_set(input logic req, input logic we, input logic [1:0] be,
                        input logic [14:0] a, input logic [15:0] d);
    ls_req = req; ls_we = we; ls_be = be; ls_addr = a; ls_wdata = d;
  endtask

  initial begin
    logic [4:0] pat;
    reset = 1'b1; if_req = 0; if_addr = '0;
    ls_set(0, 0, 2'b00, '0, '0);
    starve = 0; busy = 0; cyc = 0; after_rst = 1;
    m_ifg = 0; m_lsg = 0; s_lsg = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) poke(15'(i), 16'($urandom));
    poke(15'h20, 16'hABCD);
    poke(15'h21, 16'hABCD);
    poke(15'h22, 16'hABCD);
    cycle();                      // reset state
    reset = 1'b0;
    cycle();                      // post-reset hold-off cycle

    // Fetch stream, one grant per cycle
    if_req = 1;
    for (int i = 0; i < 4; i++) begin if_addr = 15'h10 + 15'(i); cycle(); end
    if_req = 0; cycle();

    // Contention: LS,LS,LS,IF,LS
    pat = 5'b10111;
    if_req = 1; if_addr = 15'h12;
    ls_set(1, 0, 2'b00, 15'h11, '0);
    for (int i = 0; i < 5; i++) begin cycle(); check("t2_ls_gnt", 32'(s_lsg), 32'(pat[i])); end
    if_req = 0; ls_set(0, 0, 2'b00, '0, '0); cycle(); cycle();

    // Byte stores: low, high, none
    if_req = 1; if_addr = 15'h10;
    ls_set(1, 1, 2'b01, 15'h20, 16'h0012); cycle();
    ls_set(0, 0, 2'b00, '0, '0); cycle(); cycle();
    check("t3_ram", 32'(ram[15'h20]), 32'h0000AB12);
    cycle(); if_req = 0; cycle();
    ls_set(1, 1, 2'b10, 15'h21, 16'h3400); cycle();
    ls_set(0, 0, 2'b00, '0, '0); cycle(); cycle();
    check("t4_ram_hi", 32'(ram[15'h21]), 32'h000034CD);
    ls_set(1, 1, 2'b00, 15'h22, 16'h5555); cycle();
    ls_set(0, 0, 2'b00, '0, '0); cycle();
    check("t4_ram_none", 32'(ram[15'h22]), 32'h0000ABCD);

    // IF read followed by LS load
    if_req = 1; if_addr = 15'h05; cycle();
    if_req = 0; ls_set(1, 0, 2'b00, 15'h06, '0); cycle();
    ls_set(0, 0, 2'b00, '0, '0); cycle(); cycle();

    // Reset during RMW_WAIT, then reset with a read in flight
    ls_set(1, 1, 2'b01, 15'h30, 16'h00FF); cycle();
    ls_set(0, 0, 2'b00, '0, '0); reset = 1; cycle();
    reset = 0; cycle(); cycle();
    check("t6_ram", 32'(ram[15'h30]), 32'(ref_mem[15'h30]));
    if_req = 1; if_addr = 15'h07; cycle();
    if_req = 0; reset = 1; cycle();
    reset = 0; cycle(); cycle();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(79) == 0);
      if (!if_req || m_ifg || $urandom_range(15) == 0) begin
        if_req  = ($urandom_range(2) != 0);
        if_addr = 15'($urandom_range(63));
      end
      if (!ls_req || m_lsg || $urandom_range(15) == 0)
        ls_set($urandom_range(1) == 1, $urandom_range(1) == 1, 2'($urandom_range(3)),
               15'($urandom_range(63)), 16'($urandom));
      cycle();
    end
    reset = 0; if_req = 0; ls_set(0, 0, 2'b00, '0, '0);
    repeat (RD_LAT + 3) cycle();
    for (int i = 0; i < 64; i++) check("final_ram", 32'(ram[15'(i)]), 32'(ref_mem[15'(i)]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
